// File: rtl/uart_rx_pkg.sv
// Shared state encoding and constants for the UART receive controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  // Strobe point sits this many edges past the bit centre.
  localparam int SP_OFFSET = 2;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  function automatic logic prescale_legal(input int presc);
    return (presc == PRESC_8) || (presc == PRESC_16) || (presc == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_cnt.sv
// Edge-within-bit and bit-within-frame counters; edge_nxt exposes the
// value the counter will hold next cycle so the FSM can register strobes.
module uart_rx_edge_cnt #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] presc,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  wrap,
  output logic [PRESCALE_W-1:0] edge_nxt
);

  logic [3:0] bit_nxt_s;

  assign wrap = (edge_cnt == (presc - PRESCALE_W'(1)));

  // Next counter values: clear, wrap into the next bit, or advance one edge.
  always_comb begin
    edge_nxt  = edge_cnt;
    bit_nxt_s = bit_cnt;
    if (clr) begin
      edge_nxt  = {PRESCALE_W{1'b0}};
      bit_nxt_s = 4'd0;
    end else if (wrap) begin
      edge_nxt  = {PRESCALE_W{1'b0}};
      bit_nxt_s = bit_cnt + 4'd1;
    end else begin
      edge_nxt  = edge_cnt + PRESCALE_W'(1);
      bit_nxt_s = bit_cnt;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt <= {PRESCALE_W{1'b0}};
      bit_cnt  <= 4'd0;
    end else begin
      edge_cnt <= edge_nxt;
      bit_cnt  <= bit_nxt_s;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: frame sequencing, checker strobes and data_valid.
// Define UART_RX_FSM_PARITY_EN to build the PARITY state and par_chk_en.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  par_err,
  input  logic                  strt_glitch,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  deser_en,
  output logic                  data_valid
);

  rx_state_e             state_r;
  rx_state_e             state_nxt_s;
  logic [PRESCALE_W-1:0] presc_r;
  logic [PRESCALE_W-1:0] sp_s;
  logic [PRESCALE_W-1:0] edge_nxt_s;
  logic                  armed_r;
  logic                  clr_s;
  logic                  wrap_s;
`ifdef UART_RX_FSM_PARITY_EN
  logic                  par_en_r;
`else
  logic                  unused_s;
  assign unused_s = ^{PAR_EN, par_err};
`endif

  assign sp_s = (presc_r >> 1) + PRESCALE_W'(SP_OFFSET);
  // Counters restart whenever a new frame begins or the FSM goes idle.
  assign clr_s = (state_nxt_s == IDLE) || ((state_nxt_s == START) && (state_r != START));

  uart_rx_edge_cnt #(.PRESCALE_W(PRESCALE_W)) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (clr_s),
    .presc    (presc_r),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .wrap     (wrap_s),
    .edge_nxt (edge_nxt_s)
  );

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!RX_IN && armed_r && prescale_legal(int'(Prescale))) state_nxt_s = START;
        else                                                     state_nxt_s = IDLE;
      end
      START: begin
        if (wrap_s) state_nxt_s = strt_glitch ? IDLE : DATA;
        else        state_nxt_s = START;
      end
      DATA: begin
        if (wrap_s && (bit_cnt == 4'(DATA_WIDTH))) begin
`ifdef UART_RX_FSM_PARITY_EN
          state_nxt_s = par_en_r ? PARITY : STOP;
`else
          state_nxt_s = STOP;
`endif
        end else begin
          state_nxt_s = DATA;
        end
      end
`ifdef UART_RX_FSM_PARITY_EN
      PARITY: begin
        if (wrap_s) state_nxt_s = STOP;
        else        state_nxt_s = PARITY;
      end
`endif
      STOP: begin
        if (edge_cnt == sp_s) state_nxt_s = DONE;
        else                  state_nxt_s = STOP;
      end
      DONE: begin
        if (!RX_IN) state_nxt_s = START;
        else        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, frame configuration latched while idle, and re-arm after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= IDLE;
      presc_r  <= {PRESCALE_W{1'b0}};
      armed_r  <= 1'b0;
`ifdef UART_RX_FSM_PARITY_EN
      par_en_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      armed_r <= armed_r | RX_IN;
      if (state_r == IDLE) begin
        presc_r  <= Prescale;
`ifdef UART_RX_FSM_PARITY_EN
        par_en_r <= PAR_EN;
`endif
      end
    end
  end

  // Strobes are registered from next state/edge so they align with edge_cnt==SP.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
    end else begin
      dat_samp_en <= (state_nxt_s != IDLE) && (state_nxt_s != DONE);
      strt_chk_en <= (state_nxt_s == START) && (edge_nxt_s == sp_s);
      deser_en    <= (state_nxt_s == DATA)  && (edge_nxt_s == sp_s);
`ifdef UART_RX_FSM_PARITY_EN
      par_chk_en  <= (state_nxt_s == PARITY) && (edge_nxt_s == sp_s);
`else
      par_chk_en  <= 1'b0;
`endif
      stp_chk_en  <= (state_nxt_s == STOP) && (edge_nxt_s == sp_s);
    end
  end

  // Checker results arrive after their strobe, so acceptance qualifies them live in DONE.
`ifdef UART_RX_FSM_PARITY_EN
  assign data_valid = (state_r == DONE) && !stp_err && !(par_en_r && par_err);
`else
  assign data_valid = (state_r == DONE) && !stp_err;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed self-checking bench for uart_rx_fsm (either UART_RX_FSM_PARITY_EN build).
module tb_uart_rx_fsm;

  localparam int PW = 6;

`ifdef UART_RX_FSM_PARITY_EN
  localparam int EXP_PAR      = 1;
  localparam int EXP_PAR_EDGE = 6;
  localparam int EXP_PAR_BIT  = 9;
  localparam int SAMP_P8      = 87;
  localparam int DV_PERR      = 0;
`else
  localparam int EXP_PAR      = 0;
  localparam int EXP_PAR_EDGE = 99;
  localparam int EXP_PAR_BIT  = 99;
  localparam int SAMP_P8      = 79;
  localparam int DV_PERR      = 1;
`endif

  logic          CLK, RST, RX_IN, PAR_EN, par_err, strt_glitch, stp_err;
  logic [PW-1:0] Prescale;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;

  int n_checks, n_pass, n_fail, cyc;
  int n_deser, n_strt, n_par, n_stp, n_dv, n_samp, n_done, n_edge_nz;
  int par_edge, par_bit, stp_cyc, dv_cyc, dv_first;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(PW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .par_err     (par_err),
    .strt_glitch (strt_glitch),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0; n_dv = 0; n_samp = 0;
    n_done = 0; n_edge_nz = 0; par_edge = 99; par_bit = 99;
    stp_cyc = 0; dv_cyc = 0; dv_first = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (deser_en)    n_deser++;
      if (strt_chk_en) n_strt++;
      if (stp_chk_en) begin n_stp++; stp_cyc = cyc; end
      if (par_chk_en) begin n_par++; par_edge = int'(edge_cnt); par_bit = int'(bit_cnt); end
      if (data_valid) begin
        if (n_dv == 0) dv_first = cyc;
        n_dv++;
        dv_cyc = cyc;
      end
      if (dat_samp_en) n_samp++;
      if (!dat_samp_en && (bit_cnt != 4'd0)) n_done++;
      if (edge_cnt != 6'd0) n_edge_nz++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par, input logic pbit,
                            input int presc, input int stop_cycles);
    RX_IN = 1'b0;
    run(presc);
    for (int b = 0; b < 8; b++) begin
      RX_IN = d[b];
      run(presc);
    end
    if (with_par) begin
      RX_IN = pbit;
      run(presc);
    end
    RX_IN = 1'b1;
    run(stop_cycles);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
    clear_counts();
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
    par_err = 1'b0; strt_glitch = 1'b0; stp_err = 1'b0;
    run(2);
    check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    check("rst_samp", 32'(dat_samp_en), 32'd0);
    check("rst_strobes", 32'({strt_chk_en, par_chk_en, stp_chk_en, deser_en}), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    RST = 1'b0;
    run(3);

    // Prescale 8, parity frame 0xA5 (odd parity bit 1), no errors
    clear_counts(); PAR_EN = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 8, 8);
    run(4);
    check("f1_deser", 32'(n_deser), 32'd8);
    check("f1_strt", 32'(n_strt), 32'd1);
    check("f1_par", 32'(n_par), 32'(EXP_PAR));
    check("f1_par_edge", 32'(par_edge), 32'(EXP_PAR_EDGE));
    check("f1_par_bit", 32'(par_bit), 32'(EXP_PAR_BIT));
    check("f1_stp", 32'(n_stp), 32'd1);
    check("f1_dv", 32'(n_dv), 32'd1);
    check("f1_dv_after_sp", 32'(dv_cyc - stp_cyc), 32'd1);
    check("f1_samp", 32'(n_samp), 32'(SAMP_P8));
    check("f1_done", 32'(n_done), 32'd1);
    check("f1_idle_edge", 32'(edge_cnt), 32'd0);

    // Parity error with parity enabled
    clear_counts(); par_err = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 8, 8);
    run(2);
    check("perr_dv", 32'(n_dv), 32'(DV_PERR));
    check("perr_done", 32'(n_done), 32'd1);

    // Parity error ignored without PAR_EN; mid-frame Prescale change has no effect
    clear_counts(); PAR_EN = 1'b0;
    RX_IN = 1'b0; run(3); Prescale = 6'd16; run(5);
    RX_IN = 1'b1; run(64); run(8);
    Prescale = 6'd8; par_err = 1'b0;
    run(2);
    check("nopar_dv", 32'(n_dv), 32'd1);
    check("nopar_par", 32'(n_par), 32'd0);
    check("nopar_samp", 32'(n_samp), 32'd79);

    // Start glitch: line low two cycles only
    clear_counts(); strt_glitch = 1'b1;
    RX_IN = 1'b0; run(2);
    RX_IN = 1'b1; run(18);
    check("gl_strt", 32'(n_strt), 32'd1);
    check("gl_deser", 32'(n_deser), 32'd0);
    check("gl_dv", 32'(n_dv), 32'd0);
    check("gl_samp", 32'(n_samp), 32'd8);
    check("gl_bit_cnt", 32'(bit_cnt), 32'd0);
    strt_glitch = 1'b0;

    // Stop error: DONE visited, no data_valid
    clear_counts(); stp_err = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, 8, 8);
    run(2);
    check("se_dv", 32'(n_dv), 32'd0);
    check("se_done", 32'(n_done), 32'd1);
    check("se_stp", 32'(n_stp), 32'd1);
    stp_err = 1'b0;

    // Prescale 32 back-to-back frames: line low in DONE starts the next frame
    clear_counts(); Prescale = 6'd32;
    run(2);
    send_frame(8'h3C, 1'b0, 1'b0, 32, 20);
    send_frame(8'hC3, 1'b0, 1'b0, 32, 32);
    check("b2b_dv", 32'(n_dv), 32'd2);
    check("b2b_deser", 32'(n_deser), 32'd16);
    check("b2b_strt", 32'(n_strt), 32'd2);
    check("b2b_period", 32'(dv_cyc - dv_first), 32'd308);
    check("b2b_samp", 32'(n_samp), 32'd614);
    check("b2b_done", 32'(n_done), 32'd2);

    // Reset at DATA bit 4, then line held low: no restart without a fresh edge
    Prescale = 6'd8; run(2);
    RX_IN = 1'b0; run(8);
    RX_IN = 1'b1; run(8);
    RX_IN = 1'b0; run(8);
    RX_IN = 1'b1; run(8);
    RX_IN = 1'b0; run(7);
    check("mr_bit_cnt", 32'(bit_cnt), 32'd4);
    check("mr_deser_pre", 32'(deser_en), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("mr_edge_cnt", 32'(edge_cnt), 32'd0);
    check("mr_bit_zero", 32'(bit_cnt), 32'd0);
    check("mr_deser", 32'(deser_en), 32'd0);
    check("mr_samp", 32'(dat_samp_en), 32'd0);
    run(2);
    RST = 1'b0;
    run(3);
    check("mr_no_restart", 32'(dat_samp_en), 32'd0);
    RX_IN = 1'b1; run(2);
    clear_counts();
    send_frame(8'h5A, 1'b0, 1'b0, 8, 8);
    run(2);
    check("mr_next_dv", 32'(n_dv), 32'd1);
    check("mr_next_deser", 32'(n_deser), 32'd8);
    check("mr_next_samp", 32'(n_samp), 32'd79);

    // Illegal Prescale holds IDLE while the line toggles
    clear_counts(); Prescale = 6'd12;
    for (int i = 0; i < 30; i++) begin
      RX_IN = ~RX_IN;
      run(1);
    end
    check("ill_samp", 32'(n_samp), 32'd0);
    check("ill_strt", 32'(n_strt), 32'd0);
    check("ill_edge", 32'(n_edge_nz), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per frame.
REQ-002 SHALL have parameter PRESCALE_W, default 6, meaning the width of the Prescale input and of the edge counter.
REQ-003 SHALL have port CLK  input  1  oversampling clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high.
REQ-006 SHALL have port PAR_EN  input  1  1 = the frame carries a parity bit.
REQ-007 SHALL have port Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
REQ-008 SHALL have port par_err  input  1  error result from the parity checker.
REQ-009 SHALL have port strt_glitch  input  1  error result from the start checker.
REQ-010 SHALL have port stp_err  input  1  error result from the stop checker.
REQ-011 SHALL have port edge_cnt  output  PRESCALE_W  edge position within the current bit, 0..Prescale-1.
REQ-012 SHALL have port bit_cnt  output  4  bit index within the frame.
REQ-013 SHALL have port dat_samp_en  output  1  enables the majority sampler.
REQ-014 SHALL have port strt_chk_en, par_chk_en, stp_chk_en, deser_en  output  1 each  single-cycle checker and deserializer strobes.
REQ-015 SHALL have port data_valid  output  1  single-cycle pulse; frame accepted.

Function
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE, one-hot or binary encoded.
REQ-017 Transition IDLE->START SHALL occur on the first cycle RX_IN=0; edge_cnt and bit_cnt reset to 0 on that cycle.
REQ-018 edge_cnt SHALL increment every cycle outside IDLE and wrap from Prescale-1 to 0; bit_cnt SHALL increment on each wrap.
REQ-019 Strobe point SP = Prescale/2+2: the relevant strobe SHALL be asserted for exactly the one cycle in which edge_cnt==SP.
REQ-020 dat_samp_en SHALL be 1 in every state except IDLE and DONE.
REQ-021 At SP, START SHALL assert strt_chk_en, DATA SHALL assert deser_en, PARITY SHALL assert par_chk_en, and STOP SHALL assert stp_chk_en.
REQ-022 START SHALL go to IDLE at wrap when strt_glitch=1, else to DATA.
REQ-023 DATA SHALL go to PARITY at the wrap of bit DATA_WIDTH when PAR_EN=1, else to STOP.
REQ-024 PARITY SHALL go to STOP at wrap.
REQ-025 STOP SHALL go to DONE at the cycle after SP; the remaining edges of the stop bit are not waited for.
REQ-026 DONE SHALL last one cycle and pulse data_valid=1 only when par_err=0 and stp_err=0; it SHALL then return to IDLE.
REQ-027 If RX_IN=0 in DONE, next state SHALL be START (back-to-back frame); otherwise it SHALL be IDLE.
REQ-028 PAR_EN and Prescale SHALL be sampled only in IDLE; changes mid-frame SHALL NOT take effect until the next frame.
REQ-029 A Prescale value outside {8,16,32} SHALL hold the FSM in IDLE with all strobes 0.
REQ-030 par_err SHALL be ignored when PAR_EN=0.

Reset
REQ-031 RST=1 SHALL force IDLE, edge_cnt=0, bit_cnt=0 and all strobes plus data_valid to 0 asynchronously, including mid-frame.
REQ-032 After RST deasserts, the first frame SHALL be recognised only on a fresh falling edge seen in IDLE.

Configuration
REQ-033 With macro UART_RX_FSM_PARITY_EN defined, the PARITY state and par_chk_en SHALL behave as specified above.
REQ-034 Without UART_RX_FSM_PARITY_EN, PARITY SHALL NOT be synthesised, par_chk_en SHALL be tied to 0, PAR_EN and par_err SHALL be ignored, and DATA SHALL always go to STOP.

Structure
REQ-035 The state enum, SP offset constant (2) and legal-prescale constants SHALL live in shared package uart_rx_pkg.
REQ-036 The edge/bit counter SHALL be the sub-module uart_rx_edge_cnt; the FSM SHALL stay in uart_rx_fsm.

Verification
REQ-037 Prescale=8, PAR_EN=1, odd frame 0xA5 with no errors -> 8 deser_en pulses, par_chk_en at edge 6 of bit 9, data_valid pulse 1 cycle after the stop SP.
REQ-038 RX_IN low for 2 cycles only, strt_glitch=1 -> return to IDLE at the end of bit 0, no deser_en, no data_valid.
REQ-039 stp_err=1 in STOP -> DONE is entered and data_valid stays 0.
REQ-040 Prescale=32, PAR_EN=0, two back-to-back frames with RX_IN=0 in DONE -> START entered directly and 2 data_valid pulses.
REQ-041 RST pulsed at DATA bit 4 -> all outputs 0 immediately, IDLE, and the next frame decodes correctly.
REQ-042 Prescale=12 -> FSM remains in IDLE despite RX_IN toggling.
